motor_ramp_controller: RTL and testbench

Soft-start/soft-stop stage directly upstream of pwm_generator. Converts the elevator controller's run request and target speed into a rate-limited 8-bit duty_cycle, so that the cab motor never sees a step change in drive. Emergency stop forces zero drive immediately. The duty_cycle output connects straight to pwm_generator.duty_cycle.

---
 rtl/motor_ramp_if.sv | 23 ++
 rtl/motor_ramp_controller.sv | 139 +++++++++++++
 tb/tb_motor_ramp_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/motor_ramp_if.sv
// Run/target request in, rate-limited duty and state status out, between the
// elevator controller (master) and the ramp stage (slave).
interface motor_ramp_if;
  logic       run;
  logic [7:0] target_duty;
  logic       estop;
  logic       fault_clr;
  logic [7:0] duty_cycle;
  logic       busy;
  logic       at_speed;
  logic       stopped;
  logic       fault;

  modport master (
    output run, target_duty, estop, fault_clr,
    input  duty_cycle, busy, at_speed, stopped, fault
  );

  modport slave (
    input  run, target_duty, estop, fault_clr,
    output duty_cycle, busy, at_speed, stopped, fault
  );
endinterface

// File: rtl/motor_ramp_controller.sv
// Soft-start/soft-stop duty ramp feeding pwm_generator; estop forces zero drive.
// Optional sticky estop (needs a fault_clr pulse to leave): define RAMP_FAULT_LATCH_EN.
module motor_ramp_controller #(
  parameter int unsigned STEP     = 4,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic         clk,
  input  logic         reset_n,
  motor_ramp_if.slave  bus
);
  localparam int unsigned   CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [8:0]    STEP9     = 9'(STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_ESTOP
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [7:0]    r_duty, w_nxt_duty;
  logic [CW-1:0] r_cnt, w_nxt_cnt, w_cnt_inc;
  logic          r_busy, r_at_speed, r_stopped, r_fault;

  logic [7:0] w_setpt;
  logic [8:0] w_sp9, w_d9, w_up9, w_up_sat, w_up, w_dn9, w_dn;
  logic       w_tick, w_estop_exit;

  assign w_setpt = bus.run ? bus.target_duty : 8'd0;
  assign w_sp9   = {1'b0, w_setpt};
  assign w_d9    = {1'b0, r_duty};

  // 9-bit step arithmetic so neither direction can wrap
  assign w_up9    = w_d9 + STEP9;
  assign w_up_sat = (w_up9 > 9'd255) ? 9'd255 : w_up9;
  assign w_up     = (w_up_sat > w_sp9) ? w_sp9 : w_up_sat;
  assign w_dn9    = (w_d9 < STEP9) ? 9'd0 : (w_d9 - STEP9);
  assign w_dn     = (w_dn9 < w_sp9) ? w_sp9 : w_dn9;

  assign w_tick    = (r_cnt == TICK_LAST);
  assign w_cnt_inc = w_tick ? '0 : (r_cnt + CW'(1));

`ifdef RAMP_FAULT_LATCH_EN
  logic r_clr_seen;

  // a clear only counts once estop has been released
  always_ff @(posedge clk) begin
    if (!reset_n)                                      r_clr_seen <= 1'b0;
    else if (r_state != S_ESTOP || w_nxt_state != S_ESTOP) r_clr_seen <= 1'b0;
    else if (!bus.estop && bus.fault_clr)              r_clr_seen <= 1'b1;
  end

  assign w_estop_exit = !bus.estop && !bus.run && (r_clr_seen || bus.fault_clr);
`else
  logic w_unused_fault_clr;
  assign w_unused_fault_clr = bus.fault_clr;
  assign w_estop_exit       = !bus.estop && !bus.run;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_duty     <= 8'd0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_at_speed <= 1'b0;
      r_stopped  <= 1'b1;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_duty     <= w_nxt_duty;
      r_cnt      <= w_nxt_cnt;
      r_busy     <= (w_nxt_state == S_ACCEL) || (w_nxt_state == S_DECEL);
      r_at_speed <= (w_nxt_state == S_CRUISE);
      r_stopped  <= (w_nxt_state == S_IDLE);
      r_fault    <= (w_nxt_state == S_ESTOP);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_duty  = r_duty;
    w_nxt_cnt   = r_cnt;
    if (bus.estop) begin
      w_nxt_state = S_ESTOP;
      w_nxt_duty  = 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt_duty = 8'd0;
          if (w_setpt != 8'd0) w_nxt_state = S_ACCEL;
        end
        S_ACCEL: begin
          // a zero setpoint always leaves through DECEL so it ends in IDLE
          if (w_sp9 < w_d9 || w_setpt == 8'd0) begin
            w_nxt_state = S_DECEL;
          end else begin
            w_nxt_cnt = w_cnt_inc;
            if (w_tick) begin
              w_nxt_duty = w_up[7:0];
              if (w_up == w_sp9) w_nxt_state = S_CRUISE;
            end
          end
        end
        S_CRUISE: begin
          if (w_sp9 > w_d9)      w_nxt_state = S_ACCEL;
          else if (w_sp9 < w_d9) w_nxt_state = S_DECEL;
        end
        S_DECEL: begin
          if (w_sp9 > w_d9) begin
            w_nxt_state = S_ACCEL;
          end else begin
            w_nxt_cnt = w_cnt_inc;
            if (w_tick) begin
              w_nxt_duty = w_dn[7:0];
              if (w_dn == w_sp9)
                w_nxt_state = (w_setpt == 8'd0) ? S_IDLE : S_CRUISE;
            end
          end
        end
        S_ESTOP: begin
          w_nxt_duty = 8'd0;
          if (w_estop_exit) w_nxt_state = S_IDLE;
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_duty  = 8'd0;
        end
      endcase
    end
    // every state entry restarts the prescaler, including direction reversal
    if (w_nxt_state != r_state) w_nxt_cnt = '0;
  end

  assign bus.duty_cycle = r_duty;
  assign bus.busy       = r_busy;
  assign bus.at_speed   = r_at_speed;
  assign bus.stopped    = r_stopped;
  assign bus.fault      = r_fault;
endmodule

// File: tb/tb_motor_ramp_controller.sv
// Scoreboard bench: each stimulus pushes the expected output changes with their
// cycle stamps; a negedge monitor pops one entry per observed change.
module tb_motor_ramp_controller;
  localparam int TD = 8;
  localparam int ST = 4;
  localparam logic [3:0] F_BUSY = 4'b1000;
  localparam logic [3:0] F_CRU  = 4'b0100;
  localparam logic [3:0] F_STOP = 4'b0010;
  localparam logic [3:0] F_FLT  = 4'b0001;

  typedef struct {
    int         cyc;
    int         duty;
    logic [3:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  motor_ramp_if bus();

  motor_ramp_controller #(.STEP(ST), .TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [11:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int flg();
    return int'({bus.busy, bus.at_speed, bus.stopped, bus.fault});
  endfunction

  always @(negedge clk) begin
    logic [11:0] s;
    exp_t        e;
    s = {bus.duty_cycle, bus.busy, bus.at_speed, bus.stopped, bus.fault};
    if (mon_en && s !== prev) begin
      if (sb.size() == 0) begin
        chk("spurious_change", int'(s), int'(prev));
      end else begin
        e = sb.pop_front();
        chk("duty", int'(s[11:4]), e.duty);
        chk("flags", int'(s[3:0]), int'(e.fl));
        chk("cycle", cyc, e.cyc);
      end
    end
    prev <= s;
  end

  task automatic push(input int c, input int d, input logic [3:0] f);
    exp_t e;
    e.cyc = c; e.duty = d; e.fl = f;
    sb.push_back(e);
  endtask

  // expected ramp from 'from' toward 'to', one step per TD cycles after c0
  task automatic ramp(input int c0, input int from, input int to, input logic [3:0] endfl,
                      input int maxn, output int lc, output int lv);
    int v, k;
    v = from; k = 0;
    while (v != to && (maxn == 0 || k < maxn)) begin
      k++;
      if (to > v) v = (v + ST > to) ? to : v + ST;
      else        v = (v - ST < to) ? to : v - ST;
      push(c0 + TD * k, v, (v == to) ? endfl : F_BUSY);
    end
    lc = c0 + TD * k;
    lv = v;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while (sb.size() != 0 && k < lim) begin
      @(negedge clk); #1;
      k++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", sb.size());
    $fatal(1);
  end

  initial begin
    int c0, lc, lv;
    bus.run = 1'b0; bus.target_duty = 8'd0; bus.estop = 1'b0; bus.fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(bus.duty_cycle), 0);
    chk("rst_flags", flg(), int'(F_STOP));
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_hold_flags", flg(), int'(F_STOP));

    // soft start to 64, then soft stop
    @(negedge clk); bus.run = 1'b1; bus.target_duty = 8'd64; c0 = cyc + 1;
    push(c0, 0, F_BUSY); ramp(c0, 0, 64, F_CRU, 0, lc, lv); drain(200);
    @(negedge clk); bus.run = 1'b0; c0 = cyc + 1;
    push(c0, 64, F_BUSY); ramp(c0, 64, 0, F_STOP, 0, lc, lv); drain(200);

    // top-end clamp 252 -> 255 and bottom clamp 3 -> 0
    @(negedge clk); bus.run = 1'b1; bus.target_duty = 8'd255; c0 = cyc + 1;
    push(c0, 0, F_BUSY); ramp(c0, 0, 255, F_CRU, 0, lc, lv); drain(700);
    @(negedge clk); bus.run = 1'b0; c0 = cyc + 1;
    push(c0, 255, F_BUSY); ramp(c0, 255, 0, F_STOP, 0, lc, lv); drain(700);

    // partial last step 4,8,10; retarget up from cruise, then down
    @(negedge clk); bus.run = 1'b1; bus.target_duty = 8'd10; c0 = cyc + 1;
    push(c0, 0, F_BUSY); ramp(c0, 0, 10, F_CRU, 0, lc, lv); drain(100);
    @(negedge clk); bus.target_duty = 8'd128; c0 = cyc + 1;
    push(c0, 10, F_BUSY); ramp(c0, 10, 128, F_CRU, 0, lc, lv); drain(300);
    @(negedge clk); bus.target_duty = 8'd40; c0 = cyc + 1;
    push(c0, 128, F_BUSY); ramp(c0, 128, 40, F_CRU, 0, lc, lv); drain(250);

    // reversal mid-DECEL: prescaler restarts, first up-step TD cycles later
    @(negedge clk); bus.target_duty = 8'd10; c0 = cyc + 1;
    push(c0, 40, F_BUSY); ramp(c0, 40, 10, F_CRU, 3, lc, lv);
    wait_cyc(lc + 3);
    bus.target_duty = 8'd200; c0 = cyc + 1;
    ramp(c0, lv, 200, F_CRU, 0, lc, lv); drain(500);

    // synchronous reset mid-DECEL at 80
    @(negedge clk); bus.run = 1'b0; c0 = cyc + 1;
    push(c0, 200, F_BUSY); ramp(c0, 200, 0, F_STOP, 30, lc, lv);
    wait_cyc(lc + 2);
    reset_n = 1'b0; push(cyc + 1, 0, F_STOP);
    @(negedge clk); reset_n = 1'b1;
    drain(300);

    // reset glitch between edges mid-ACCEL, then estop at duty 100
    @(negedge clk); bus.run = 1'b1; bus.target_duty = 8'd160; c0 = cyc + 1;
    push(c0, 0, F_BUSY); ramp(c0, 0, 160, F_CRU, 25, lc, lv);
    wait_cyc(c0 + 20);
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    wait_cyc(lc + 3);
    bus.estop = 1'b1; push(cyc + 1, 0, F_FLT);
    drain(300);

    // released with run still high: no restart
    @(negedge clk); bus.estop = 1'b0;
    repeat (16) @(negedge clk);
    // clear pulse during estop is ignored
    bus.estop = 1'b1; bus.run = 1'b0;
    repeat (2) @(negedge clk);
    bus.fault_clr = 1'b1;
    @(negedge clk); bus.fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    bus.estop = 1'b0; c0 = cyc + 1;
`ifdef RAMP_FAULT_LATCH_EN
    repeat (10) @(negedge clk);
    bus.fault_clr = 1'b1; c0 = cyc + 1;
    push(c0, 0, F_STOP);
    @(negedge clk); bus.fault_clr = 1'b0;
`else
    push(c0, 0, F_STOP);
`endif
    drain(40);
    chk("estop_exit_flags", flg(), int'(F_STOP));

    // run with zero target stays stopped
    @(negedge clk); bus.run = 1'b1; bus.target_duty = 8'd0;
    repeat (20) @(negedge clk);
    chk("zero_target_flags", flg(), int'(F_STOP));
    chk("zero_target_duty", int'(bus.duty_cycle), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
